// File: rtl/lsu_ctrl.sv
// Load/store control stage: decodes EXU memory ops, checks alignment,
// sequences one Memory access with wait states and holds the result for WBU.
module lsu_ctrl #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [2:0]      in_funct3,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data,
    output logic            mem_rd_en,
    output logic            mem_wr_en,
    output logic [31:0]     mem_len,
    output logic            mem_load_unsign,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_reg_wen,
    output logic            out_misalign,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;

    logic [XLEN-1:0] op_addr;
    logic [XLEN-1:0] op_wdata;
    logic [2:0]      op_len;
    logic            op_uns;
    logic            op_load;
    logic            op_store;

    logic [2:0]      dec_len;
    logic            dec_uns;
    logic            dec_legal;
    logic            is_mem;
    logic            illegal;
    logic            misalign;
    logic            fault;
    logic            go_mem;
    logic            accept;
    logic            last;
    logic            in_access;

    always_comb begin
        dec_len   = 3'd0;
        dec_uns   = 1'b0;
        dec_legal = 1'b0;
        unique case (in_funct3)
            3'b000: begin
                dec_len   = 3'd1;
                dec_legal = 1'b1;
            end
            3'b001: begin
                dec_len   = 3'd2;
                dec_legal = 1'b1;
            end
            3'b010: begin
                dec_len   = 3'd4;
                dec_legal = 1'b1;
            end
            3'b100: begin
                dec_len   = 3'd1;
                dec_uns   = 1'b1;
                dec_legal = in_is_load;
            end
            3'b101: begin
                dec_len   = 3'd2;
                dec_uns   = 1'b1;
                dec_legal = in_is_load;
            end
            default: ;
        endcase
    end

    assign is_mem    = in_is_load | in_is_store;
    assign illegal   = is_mem & ~dec_legal;
    // Illegal encodings never report misalign, whatever the address.
    assign misalign  = is_mem & dec_legal &
                       (((dec_len == 3'd2) & in_addr[0]) |
                        ((dec_len == 3'd4) & (|in_addr[1:0])));
    assign fault     = illegal | misalign;
    assign go_mem    = is_mem & ~fault;
    assign accept    = in_valid & (state == IDLE);
    assign last      = (cnt == '0);
    assign in_access = (state == ACCESS);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = go_mem ? ACCESS : RESP;
                    if (go_mem) cnt_nx = CNT_INIT;
                end
            end
            ACCESS: begin
                if (last) state_nx = RESP;
                else      cnt_nx   = cnt - CW'(1);
            end
            RESP: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_addr      <= '0;
            op_wdata     <= '0;
            op_len       <= '0;
            op_uns       <= 1'b0;
            op_load      <= 1'b0;
            op_store     <= 1'b0;
            out_result   <= '0;
            out_rd       <= '0;
            out_reg_wen  <= 1'b0;
            out_misalign <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (accept) begin
            op_addr      <= in_addr;
            op_wdata     <= in_wdata;
            op_len       <= dec_len;
            op_uns       <= dec_uns;
            op_load      <= in_is_load & go_mem;
            op_store     <= in_is_store & go_mem;
            out_result   <= in_addr;
            out_rd       <= in_rd;
            out_reg_wen  <= in_reg_wen & ~fault;
            out_misalign <= misalign;
            out_illegal  <= illegal;
        end else if (in_access && last && op_load) begin
            out_result   <= mem_rdata;
        end
    end

    // Memory sees a quiet bus except while the access is in flight.
    assign mem_addr        = in_access ? op_addr : '0;
    assign mem_data        = in_access ? op_wdata : '0;
    assign mem_len         = in_access ? 32'(op_len) : 32'd0;
    assign mem_load_unsign = in_access & op_uns;
    assign mem_rd_en       = in_access & op_load;
    assign mem_wr_en       = in_access & op_store & last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: three instances (LATENCY 1, 3, 4) driven by directed
// and random ops, checked against a size/legality model of the stage.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid        [3];
    logic        in_ready        [3];
    logic [31:0] in_addr         [3];
    logic [31:0] in_wdata        [3];
    logic [2:0]  in_funct3       [3];
    logic        in_is_load      [3];
    logic        in_is_store     [3];
    logic [4:0]  in_rd           [3];
    logic        in_reg_wen      [3];
    logic [31:0] mem_addr        [3];
    logic [31:0] mem_data        [3];
    logic        mem_rd_en       [3];
    logic        mem_wr_en       [3];
    logic [31:0] mem_len         [3];
    logic        mem_load_unsign [3];
    logic [31:0] mem_rdata       [3];
    logic        out_valid       [3];
    logic        out_ready       [3];
    logic [31:0] out_result      [3];
    logic [4:0]  out_rd          [3];
    logic        out_reg_wen     [3];
    logic        out_misalign    [3];
    logic        out_illegal     [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lsu_ctrl #(
            .XLEN   (32),
            .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .in_valid       (in_valid[g]),
            .in_ready       (in_ready[g]),
            .in_addr        (in_addr[g]),
            .in_wdata       (in_wdata[g]),
            .in_funct3      (in_funct3[g]),
            .in_is_load     (in_is_load[g]),
            .in_is_store    (in_is_store[g]),
            .in_rd          (in_rd[g]),
            .in_reg_wen     (in_reg_wen[g]),
            .mem_addr       (mem_addr[g]),
            .mem_data       (mem_data[g]),
            .mem_rd_en      (mem_rd_en[g]),
            .mem_wr_en      (mem_wr_en[g]),
            .mem_len        (mem_len[g]),
            .mem_load_unsign(mem_load_unsign[g]),
            .mem_rdata      (mem_rdata[g]),
            .out_valid      (out_valid[g]),
            .out_ready      (out_ready[g]),
            .out_result     (out_result[g]),
            .out_rd         (out_rd[g]),
            .out_reg_wen    (out_reg_wen[g]),
            .out_misalign   (out_misalign[g]),
            .out_illegal    (out_illegal[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    typedef struct {
        bit          rdy0;
        int          lat;
        int          rd_cnt;
        int          wr_cnt;
        int          wr_cyc;
        int          len;
        bit          uns;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [31:0] result;
        bit          reg_wen;
        bit          mis;
        bit          ill;
        logic [4:0]  rd;
        bit          resp_idle;
        bit          rdy_resp;
        bit          unstable;
        bit          rdy_after;
        bit          valid_after;
        bit          timeout;
    } obs_t;

    typedef struct {
        int          lat;
        int          rd_cnt;
        int          wr_cnt;
        int          size;
        bit          uns;
        bit          ill;
        bit          mis;
        bit          mem;
        logic [31:0] result;
        bit          reg_wen;
    } exp_t;

    // Access size is 2**funct3[1:0]; bit 2 selects zero extension (loads only).
    function automatic exp_t model(input int d, input logic [31:0] addr,
                                   input logic [2:0] f3, input bit ld,
                                   input bit st, input bit wen,
                                   input logic [31:0] rdata);
        exp_t e;
        int   sz;
        bit   legal;
        sz       = 1 << f3[1:0];
        legal    = (f3[1:0] != 2'd3) && (!f3[2] || (ld && sz != 4));
        e.size   = sz;
        e.uns    = f3[2];
        e.ill    = (ld || st) && !legal;
        e.mis    = (ld || st) && legal && ((addr % sz) != 0);
        e.mem    = (ld || st) && !e.ill && !e.mis;
        e.lat    = e.mem ? lat_of(d) + 1 : 1;
        e.rd_cnt = (e.mem && ld) ? lat_of(d) : 0;
        e.wr_cnt = (e.mem && st) ? 1 : 0;
        e.result = (e.mem && ld) ? rdata : addr;
        e.reg_wen = wen && !e.ill && !e.mis;
        return e;
    endfunction

    task automatic do_op(input int d, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input bit ld, input bit st, input logic [4:0] rd,
                         input bit wen, input logic [31:0] rdata,
                         input int hold, output obs_t o);
        int cyc;
        int lat;
        lat = lat_of(d);
        o = '{default: 0};
        o.resp_idle = 1'b1;
        @(negedge clk);
        in_valid[d]    = 1'b1;
        in_addr[d]     = addr;
        in_wdata[d]    = wdata;
        in_funct3[d]   = f3;
        in_is_load[d]  = ld;
        in_is_store[d] = st;
        in_rd[d]       = rd;
        in_reg_wen[d]  = wen;
        mem_rdata[d]   = $urandom;
        o.rdy0 = in_ready[d];
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_addr[d]  = $urandom;
        in_wdata[d] = $urandom;
        cyc = 1;
        while (!out_valid[d]) begin
            if (cyc > 20) begin
                o.timeout = 1'b1;
                break;
            end
            mem_rdata[d] = (cyc == lat) ? rdata : $urandom;
            if (mem_rd_en[d]) o.rd_cnt++;
            if (mem_wr_en[d]) begin
                o.wr_cnt++;
                o.wr_cyc = cyc;
            end
            if (mem_rd_en[d] || mem_wr_en[d]) begin
                o.len   = int'(mem_len[d]);
                o.uns   = mem_load_unsign[d];
                o.maddr = mem_addr[d];
                o.mdata = mem_data[d];
            end
            @(negedge clk);
            cyc++;
        end
        o.lat       = cyc;
        o.result    = out_result[d];
        o.reg_wen   = out_reg_wen[d];
        o.mis       = out_misalign[d];
        o.ill       = out_illegal[d];
        o.rd        = out_rd[d];
        o.rdy_resp  = in_ready[d];
        o.resp_idle = !mem_rd_en[d] && !mem_wr_en[d] && (mem_len[d] == 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid[d] || out_result[d] !== o.result ||
                out_reg_wen[d] !== o.reg_wen || in_ready[d])
                o.unstable = 1'b1;
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d]  = 1'b0;
        o.rdy_after   = in_ready[d];
        o.valid_after = out_valid[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (out_valid[d] !== 1'b0 || mem_len[d] !== 32'd0 ||
                mem_rd_en[d] !== 1'b0 || mem_wr_en[d] !== 1'b0 ||
                out_result[d] !== 32'd0 || mem_addr[d] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outs d=%0d valid=%b len=%0d rd=%b wr=%b res=%h exp all 0",
                         d, out_valid[d], mem_len[d], mem_rd_en[d], mem_wr_en[d],
                         out_result[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (in_ready[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready d=%0d got %b exp 1", d, in_ready[d]);
            end
        end
    endtask

    task automatic test_lw();
        obs_t o;
        do_op(0, 32'h8000_0010, 32'h0, 3'b010, 1, 0, 5'd7, 1, 32'hDEAD_BEEF, 0, o);
        n_chk++;
        if (o.rd_cnt !== 1 || o.len !== 4 || o.lat !== 2) begin
            n_fail++;
            $display("FAIL lw_timing rd_cnt=%0d len=%0d lat=%0d exp 1 4 2",
                     o.rd_cnt, o.len, o.lat);
        end
        n_chk++;
        if (o.result !== 32'hDEAD_BEEF || o.reg_wen !== 1'b1 || o.rd !== 5'd7) begin
            n_fail++;
            $display("FAIL lw_result res=%h wen=%b rd=%0d exp deadbeef 1 7",
                     o.result, o.reg_wen, o.rd);
        end
    endtask

    task automatic test_sb();
        obs_t o;
        do_op(1, 32'h8000_0003, 32'h1234_5678, 3'b000, 0, 1, 5'd0, 0, 32'h0, 0, o);
        n_chk++;
        if (o.wr_cnt !== 1 || o.wr_cyc !== 3 || o.rd_cnt !== 0) begin
            n_fail++;
            $display("FAIL sb_pulse wr_cnt=%0d wr_cyc=%0d rd_cnt=%0d exp 1 3 0",
                     o.wr_cnt, o.wr_cyc, o.rd_cnt);
        end
        n_chk++;
        if (o.len !== 1 || o.mdata !== 32'h1234_5678 || o.maddr !== 32'h8000_0003) begin
            n_fail++;
            $display("FAIL sb_bus len=%0d data=%h addr=%h exp 1 12345678 80000003",
                     o.len, o.mdata, o.maddr);
        end
        n_chk++;
        if (o.result !== 32'h8000_0003 || o.lat !== 4) begin
            n_fail++;
            $display("FAIL sb_result res=%h lat=%0d exp 80000003 4", o.result, o.lat);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        do_op(0, 32'h8000_0001, 32'h0, 3'b001, 1, 0, 5'd3, 1, 32'h0, 0, o);
        n_chk++;
        if (o.mis !== 1'b1 || o.ill !== 1'b0 || o.reg_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL lh_misalign mis=%b ill=%b wen=%b exp 1 0 0",
                     o.mis, o.ill, o.reg_wen);
        end
        n_chk++;
        if (o.rd_cnt + o.wr_cnt !== 0 || o.lat !== 1) begin
            n_fail++;
            $display("FAIL lh_nopulse pulses=%0d lat=%0d exp 0 1",
                     o.rd_cnt + o.wr_cnt, o.lat);
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        do_op(1, 32'h8000_0003, 32'h0, 3'b110, 1, 0, 5'd4, 1, 32'h0, 0, o);
        n_chk++;
        if (o.ill !== 1'b1 || o.mis !== 1'b0 || o.reg_wen !== 1'b0 ||
            o.rd_cnt + o.wr_cnt !== 0 || o.lat !== 1) begin
            n_fail++;
            $display("FAIL ld110 ill=%b mis=%b wen=%b pulses=%0d lat=%0d exp 1 0 0 0 1",
                     o.ill, o.mis, o.reg_wen, o.rd_cnt + o.wr_cnt, o.lat);
        end
        do_op(1, 32'h8000_0008, 32'h55, 3'b100, 0, 1, 5'd0, 0, 32'h0, 0, o);
        n_chk++;
        if (o.ill !== 1'b1 || o.wr_cnt !== 0 || o.rd_cnt !== 0 || o.lat !== 1) begin
            n_fail++;
            $display("FAIL sw100 ill=%b wr=%0d rd=%0d lat=%0d exp 1 0 0 1",
                     o.ill, o.wr_cnt, o.rd_cnt, o.lat);
        end
    endtask

    task automatic test_passthru();
        obs_t o;
        do_op(0, 32'h0000_0042, 32'h0, 3'b000, 0, 0, 5'd9, 1, 32'h0, 5, o);
        n_chk++;
        if (o.result !== 32'h42 || o.reg_wen !== 1'b1 || o.lat !== 1) begin
            n_fail++;
            $display("FAIL pass_result res=%h wen=%b lat=%0d exp 42 1 1",
                     o.result, o.reg_wen, o.lat);
        end
        n_chk++;
        if (o.unstable || o.rdy_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_hold unstable=%b ready=%b exp 0 0",
                     o.unstable, o.rdy_resp);
        end
        n_chk++;
        if (o.rdy_after !== 1'b1 || o.valid_after !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_release ready=%b valid=%b exp 1 0",
                     o.rdy_after, o.valid_after);
        end
    endtask

    task automatic test_reset_access();
        obs_t o;
        bit   wr_seen = 0;
        bit   val_seen = 0;
        @(negedge clk);
        in_valid[2]    = 1'b1;
        in_addr[2]     = 32'h8000_0100;
        in_wdata[2]    = 32'hCAFE_F00D;
        in_funct3[2]   = 3'b010;
        in_is_load[2]  = 1'b0;
        in_is_store[2] = 1'b1;
        in_reg_wen[2]  = 1'b0;
        @(negedge clk);
        in_valid[2] = 1'b0;
        in_is_store[2] = 1'b0;
        wr_seen |= mem_wr_en[2];
        @(negedge clk);
        wr_seen |= mem_wr_en[2];
        rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid[2] !== 1'b0 || mem_wr_en[2] !== 1'b0 || mem_len[2] !== 32'd0 ||
            mem_addr[2] !== 32'd0 || mem_data[2] !== 32'd0 || out_result[2] !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_access_outs valid=%b wr=%b len=%0d addr=%h data=%h exp 0",
                     out_valid[2], mem_wr_en[2], mem_len[2], mem_addr[2], mem_data[2]);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wr_seen |= mem_wr_en[2];
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_access_ready got %b exp 1", in_ready[2]);
        end
        for (int i = 0; i < 6; i++) begin
            wr_seen  |= mem_wr_en[2];
            val_seen |= out_valid[2];
            @(negedge clk);
        end
        n_chk++;
        if (wr_seen || val_seen) begin
            n_fail++;
            $display("FAIL rst_access_abandon wr_seen=%b valid_seen=%b exp 0 0",
                     wr_seen, val_seen);
        end
        do_op(2, 32'h8000_0203, 32'h0, 3'b100, 1, 0, 5'd11, 1, 32'h0000_00AB, 0, o);
        n_chk++;
        if (o.result !== 32'hAB || o.uns !== 1'b1 || o.len !== 1 || o.lat !== 5 ||
            o.rd_cnt !== 4 || o.rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL lbu_after_rst res=%h uns=%b len=%0d lat=%0d rd=%0d exp ab 1 1 5 4",
                     o.result, o.uns, o.len, o.lat, o.rd_cnt);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        int          d;
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          ld;
        bit          st;
        bit          wen;
        for (int i = 0; i < 80; i++) begin
            d     = $urandom_range(0, 2);
            kind  = $urandom_range(0, 2);
            ld    = (kind == 0);
            st    = (kind == 1);
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            f3    = 3'($urandom_range(0, 7));
            rd    = 5'($urandom_range(0, 31));
            wen   = 1'($urandom_range(0, 1));
            e = model(d, addr, f3, ld, st, wen, rdata);
            do_op(d, addr, wdata, f3, ld, st, rd, wen, rdata,
                  $urandom_range(0, 2), o);
            n_chk++;
            if (o.timeout || !o.rdy0 || o.lat !== e.lat) begin
                n_fail++;
                $display("FAIL rnd_lat i=%0d d=%0d to=%b rdy=%b got %0d exp %0d",
                         i, d, o.timeout, o.rdy0, o.lat, e.lat);
            end
            n_chk++;
            if (o.rd_cnt !== e.rd_cnt || o.wr_cnt !== e.wr_cnt) begin
                n_fail++;
                $display("FAIL rnd_pulse i=%0d rd=%0d wr=%0d exp %0d %0d",
                         i, o.rd_cnt, o.wr_cnt, e.rd_cnt, e.wr_cnt);
            end
            n_chk++;
            if (o.result !== e.result || o.reg_wen !== e.reg_wen ||
                o.mis !== e.mis || o.ill !== e.ill || o.rd !== rd) begin
                n_fail++;
                $display("FAIL rnd_out i=%0d res=%h wen=%b mis=%b ill=%b rd=%0d exp %h %b %b %b %0d",
                         i, o.result, o.reg_wen, o.mis, o.ill, o.rd,
                         e.result, e.reg_wen, e.mis, e.ill, rd);
            end
            n_chk++;
            if (!o.resp_idle || o.unstable || o.rdy_resp || !o.rdy_after || o.valid_after) begin
                n_fail++;
                $display("FAIL rnd_resp i=%0d idle=%b unstable=%b rdy=%b after=%b/%b exp 1 0 0 1 0",
                         i, o.resp_idle, o.unstable, o.rdy_resp, o.rdy_after, o.valid_after);
            end
            if (e.mem) begin
                n_chk++;
                if (o.len !== e.size || o.uns !== e.uns || o.maddr !== addr ||
                    (st && (o.mdata !== wdata || o.wr_cyc !== lat_of(d)))) begin
                    n_fail++;
                    $display("FAIL rnd_bus i=%0d len=%0d uns=%b addr=%h data=%h wcyc=%0d exp %0d %b %h %h",
                             i, o.len, o.uns, o.maddr, o.mdata, o.wr_cyc,
                             e.size, e.uns, addr, wdata);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d]    = 1'b0;
            in_addr[d]     = '0;
            in_wdata[d]    = '0;
            in_funct3[d]   = '0;
            in_is_load[d]  = 1'b0;
            in_is_store[d] = 1'b0;
            in_rd[d]       = '0;
            in_reg_wen[d]  = 1'b0;
            mem_rdata[d]   = '0;
            out_ready[d]   = 1'b0;
        end
        #12;
        test_reset();
        test_lw();
        test_sb();
        test_misalign();
        test_illegal();
        test_passthru();
        test_reset_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
